// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the pipelined data memory
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_RSV = 2'b00,
      SZ_W   = 2'b01,
      SZ_H   = 2'b10,
      SZ_B   = 2'b11
   } size_e;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bus between the MEM stage and the data memory
interface dmem_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering: store enables/replication, load extract/extend
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_st_size,
   input  logic [1:0]  i_st_lane,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_st_be,
   output logic [31:0] o_st_data,
   input  logic [1:0]  i_ld_size,
   input  logic [1:0]  i_ld_lane,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_ld_word,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_shifted;
   logic [15:0] w_half;
   logic [7:0]  w_byte;

   always_comb begin
      o_st_be   = 4'b0000;
      o_st_data = i_st_data;
      case (i_st_size)
         SZ_W: begin
            o_st_be   = 4'b1111;
            o_st_data = i_st_data;
         end
         SZ_H: begin
            o_st_be   = i_st_lane[1] ? 4'b1100 : 4'b0011;
            o_st_data = {2{i_st_data[15:0]}};
         end
         SZ_B: begin
            o_st_be   = 4'b0001 << i_st_lane;
            o_st_data = {4{i_st_data[7:0]}};
         end
         default: begin
            o_st_be   = 4'b0000;
            o_st_data = i_st_data;
         end
      endcase
   end

   // Lane is already aligned for the access size, so shifting by it lands the field at bit 0.
   assign w_shifted = i_ld_word >> {i_ld_lane, 3'b000};
   assign w_half    = w_shifted[15:0];
   assign w_byte    = w_shifted[7:0];

   always_comb begin
      o_ld_data = '0;
      case (i_ld_size)
         SZ_W:    o_ld_data = i_ld_word;
         SZ_H:    o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
         SZ_B:    o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
         default: o_ld_data = '0;
      endcase
   end

endmodule

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - pipelined data memory, 1-cycle response, hardware clear after reset
// Optional: DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_pipe
   import dmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
   parameter int          DEPTH     = 1024,
   localparam int         AW        = $clog2(DEPTH)
) (
   input  logic  clk,
   input  logic  rst,
   output logic  init_done,
   dmem_if.slave bus
);

   state_e         r_state;
   logic [AW-1:0]  r_clr_ptr;
   logic           r_init_done;
   logic           r_req_ready;
   logic           r_resp_valid;
   logic           r_resp_err;
   logic           r_resp_load;
   logic [1:0]     r_ld_size;
   logic [1:0]     r_ld_lane;
   logic           r_ld_unsigned;
   logic [31:0]    r_rd_word;
   logic [31:0]    r_mem [DEPTH];

   logic [31:0]    w_off;
   logic [AW-1:0]  w_idx;
   logic [1:0]     w_lane;
   logic           w_oob;
   logic           w_size_bad;
   logic           w_misalign;
   logic           w_err;
   logic           w_accept;
   logic           w_store;
   logic           w_clear;
   logic [3:0]     w_be;
   logic [31:0]    w_wdata_rep;
   logic [31:0]    w_ld_data;

   // Modular subtraction makes addresses below BASE wrap to huge offsets, caught by w_oob.
   assign w_off      = bus.req_addr - BASE_ADDR;
   assign w_idx      = w_off[AW+1:2];
   assign w_oob      = |w_off[31:AW+2];
   assign w_size_bad = (bus.req_size == SZ_RSV);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_misalign = ((bus.req_size == SZ_W) && (w_off[1:0] != 2'b00)) ||
                       ((bus.req_size == SZ_H) && w_off[0]);
   assign w_lane     = w_off[1:0];
`else
   assign w_misalign = 1'b0;
   assign w_lane     = (bus.req_size == SZ_W) ? 2'b00 :
                       (bus.req_size == SZ_H) ? {w_off[1], 1'b0} : w_off[1:0];
`endif

   assign w_err    = w_oob | w_size_bad | w_misalign;
   assign w_accept = bus.req_valid & r_req_ready;
   assign w_store  = w_accept & bus.req_we & ~w_err;
   assign w_clear  = (r_state == CLEAR);

   dmem_lane_align u_align (
      .i_st_size     (bus.req_size),
      .i_st_lane     (w_lane),
      .i_st_data     (bus.req_wdata),
      .o_st_be       (w_be),
      .o_st_data     (w_wdata_rep),
      .i_ld_size     (r_ld_size),
      .i_ld_lane     (r_ld_lane),
      .i_ld_unsigned (r_ld_unsigned),
      .i_ld_word     (r_rd_word),
      .o_ld_data     (w_ld_data)
   );

   // Array has no reset; its contents are zeroed by the CLEAR sweep instead.
   always_ff @(posedge clk) begin
      if (w_clear) begin
         r_mem[r_clr_ptr] <= '0;
      end else if (w_store) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
         end
      end
      if (w_accept) begin
         r_rd_word <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= CLEAR;
         r_clr_ptr     <= '0;
         r_init_done   <= 1'b0;
         r_req_ready   <= 1'b0;
         r_resp_valid  <= 1'b0;
         r_resp_err    <= 1'b0;
         r_resp_load   <= 1'b0;
         r_ld_size     <= SZ_W;
         r_ld_lane     <= 2'b00;
         r_ld_unsigned <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_clr_ptr <= r_clr_ptr + AW'(1);
               if (r_clr_ptr == AW'(DEPTH - 1)) begin
                  r_state     <= RUN;
                  r_init_done <= 1'b1;
                  r_req_ready <= 1'b1;
               end
            end
            RUN: begin
               r_init_done <= 1'b1;
               r_req_ready <= 1'b1;
            end
            default: r_state <= CLEAR;
         endcase

         r_resp_valid <= w_accept;
         r_resp_err   <= w_accept & w_err;
         r_resp_load  <= w_accept & ~bus.req_we & ~w_err;
         if (w_accept) begin
            r_ld_size     <= bus.req_size;
            r_ld_lane     <= w_lane;
            r_ld_unsigned <= bus.req_unsigned;
         end
      end
   end

   assign init_done      = r_init_done;
   assign bus.req_ready  = r_req_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_err   = r_resp_err;
   assign bus.resp_rdata = r_resp_load ? w_ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_pipe.sv
// tb/tb_dmem_pipe.sv - directed self-checking bench for dmem_pipe
module tb_dmem_pipe;
   import dmem_pkg::*;

   localparam int          DEPTH = 64;
   localparam logic [31:0] B     = 32'h1001_0000;

   logic clk = 1'b0;
   logic rst;
   logic init_done;
   int   checks = 0;
   int   errors = 0;

   dmem_if bus ();

   dmem_pipe #(.BASE_ADDR(B), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .init_done (init_done),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
   endtask

   task automatic resp(input string tag, input logic err, input logic [31:0] rdata);
      chk({tag, ".valid"}, {31'b0, bus.resp_valid}, 32'd1);
      chk({tag, ".err"},   {31'b0, bus.resp_err},   {31'b0, err});
      chk({tag, ".rdata"}, bus.resp_rdata, rdata);
   endtask

   task automatic single(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata);
      drive(we, size, uns, addr, wdata);
      step();
      idle();
      resp(tag, err, rdata);
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (!init_done && n < 4*DEPTH) begin
         step();
         n++;
      end
      chk(tag, n, DEPTH);
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_W;
      bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      step(); step();
      chk("rst.init_done",  {31'b0, init_done},      32'd0);
      chk("rst.req_ready",  {31'b0, bus.req_ready},  32'd0);
      chk("rst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("rst.resp_err",   {31'b0, bus.resp_err},   32'd0);
      chk("rst.resp_rdata", bus.resp_rdata,          32'd0);
      rst = 1'b0;
      wait_init("init.cycles");
      chk("init.ready", {31'b0, bus.req_ready}, 32'd1);

      single("t1.ld10", 1'b0, SZ_W, 1'b0, B + 32'h10, 32'h0, 1'b0, 32'h0);
      step();
      chk("idle.valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("idle.rdata", bus.resp_rdata,          32'd0);

      single("t2.st4", 1'b1, SZ_W, 1'b0, B + 32'h4, 32'h8765_4321, 1'b0, 32'h0);
      drive(1'b0, SZ_B, 1'b0, B + 32'h4, 32'h0); step();
      drive(1'b0, SZ_B, 1'b0, B + 32'h5, 32'h0); resp("t2.lb4", 1'b0, 32'h0000_0021); step();
      drive(1'b0, SZ_B, 1'b0, B + 32'h6, 32'h0); resp("t2.lb5", 1'b0, 32'h0000_0043); step();
      drive(1'b0, SZ_B, 1'b0, B + 32'h7, 32'h0); resp("t2.lb6", 1'b0, 32'h0000_0065); step();
      drive(1'b0, SZ_B, 1'b1, B + 32'h7, 32'h0); resp("t2.lb7", 1'b0, 32'hFFFF_FF87); step();
      idle();                                    resp("t2.lbu7", 1'b0, 32'h0000_0087);

      single("t3.sh",   1'b1, SZ_H, 1'b0, B + 32'hA, 32'h0000_BEEF, 1'b0, 32'h0);
      single("t3.lw8",  1'b0, SZ_W, 1'b0, B + 32'h8, 32'h0, 1'b0, 32'hBEEF_0000);
      single("t3.lhA",  1'b0, SZ_H, 1'b0, B + 32'hA, 32'h0, 1'b0, 32'hFFFF_BEEF);
      single("t3.lhuA", 1'b0, SZ_H, 1'b1, B + 32'hA, 32'h0, 1'b0, 32'h0000_BEEF);
      single("t3.lh8",  1'b0, SZ_H, 1'b0, B + 32'h8, 32'h0, 1'b0, 32'h0);

      single("t4.below",   1'b0, SZ_W,   1'b0, B - 32'h4,       32'h0, 1'b1, 32'h0);
      single("t4.above",   1'b0, SZ_W,   1'b0, B + 4*DEPTH,     32'h0, 1'b1, 32'h0);
      single("t4.rsv_ld",  1'b0, SZ_RSV, 1'b0, B + 32'h4,       32'h0, 1'b1, 32'h0);
      single("t4.rsv_st",  1'b1, SZ_RSV, 1'b0, B + 32'h4, 32'hDEAD_BEEF, 1'b1, 32'h0);
      single("t4.oob_st",  1'b1, SZ_W,   1'b0, B + 4*DEPTH, 32'hDEAD_BEEF, 1'b1, 32'h0);
      single("t4.keep4",   1'b0, SZ_W,   1'b0, B + 32'h4,       32'h0, 1'b0, 32'h8765_4321);
      single("t4.keep0",   1'b0, SZ_W,   1'b0, B,               32'h0, 1'b0, 32'h0);
      single("t4.last",    1'b0, SZ_W,   1'b0, B + 4*DEPTH - 4, 32'h0, 1'b0, 32'h0);

      drive(1'b1, SZ_W, 1'b0, B + 32'h20, 32'h1234_5678); step();
      drive(1'b0, SZ_W, 1'b0, B + 32'h20, 32'h0); resp("t5.st", 1'b0, 32'h0); step();
      idle(); resp("t5.ld", 1'b0, 32'h1234_5678);

`ifdef DMEM_MISALIGN_TRAP_EN
      single("t6.stw2",  1'b1, SZ_W, 1'b0, B + 32'h2,  32'hCAFE_F00D, 1'b1, 32'h0);
      single("t6.lw0",   1'b0, SZ_W, 1'b0, B,          32'h0,         1'b0, 32'h0);
      single("t6.sth11", 1'b1, SZ_H, 1'b0, B + 32'h11, 32'h0000_1111, 1'b1, 32'h0);
      single("t6.lw10",  1'b0, SZ_W, 1'b0, B + 32'h10, 32'h0,         1'b0, 32'h0);
`else
      single("t6.stw2",  1'b1, SZ_W, 1'b0, B + 32'h2,  32'hCAFE_F00D, 1'b0, 32'h0);
      single("t6.lw0",   1'b0, SZ_W, 1'b0, B,          32'h0,         1'b0, 32'hCAFE_F00D);
      single("t6.sth11", 1'b1, SZ_H, 1'b0, B + 32'h11, 32'h0000_1111, 1'b0, 32'h0);
      single("t6.lw10",  1'b0, SZ_W, 1'b0, B + 32'h10, 32'h0,         1'b0, 32'h0000_1111);
`endif

      drive(1'b0, SZ_W, 1'b0, B + 32'h4, 32'h0); step(); idle();
      chk("drop.pre_valid", {31'b0, bus.resp_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("drop.valid", {31'b0, bus.resp_valid}, 32'd0);
      chk("drop.rdata", bus.resp_rdata,          32'd0);
      chk("drop.init",  {31'b0, init_done},      32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < DEPTH/2; i++) step();
      chk("midclr.init", {31'b0, init_done}, 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_init("midclr.cycles");
      single("clr.lw4",  1'b0, SZ_W, 1'b0, B + 32'h4,  32'h0, 1'b0, 32'h0);
      single("clr.lw20", 1'b0, SZ_W, 1'b0, B + 32'h20, 32'h0, 1'b0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
